ksa_scheduler: RTL and testbench
================================

# ksa_scheduler

RC4 key-scheduling engine that fills the shared 256-byte scratch RAM with the key-permuted S array. It writes the state that the downstream `decrypter` PRGA stage reads and swaps. It sits between the key source (switches or key-search counter) and `decrypter`, and owns the scratch RAM port until it asserts `finish`.

## Interface
- `DATA_WIDTH`, 8, scratch word and key-byte width
- `ADDR_WIDTH`, 8, scratch address width (256 entries)
- `KEY_BYTES`, 3, key length in bytes
- `clk`  in  1  single clock, all logic on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `start`  in  1  level request, sampled in IDLE
- `key`  in  `KEY_BYTES*DATA_WIDTH`  secret key, MSB byte = key byte 0
- `s_addr`  out  `ADDR_WIDTH`  scratch address
- `s_data`  out  `DATA_WIDTH`  scratch write data
- `s_wren`  out  1  scratch write enable
- `s_q`  in  `DATA_WIDTH`  scratch read data, valid 1 cycle after `s_addr`
- `finish`  out  1  high in DONE

## Operation
- States: IDLE, INIT, RD_I, CALC_J, WR_I, WR_J, DONE.
- **IDLE:**
  - `start`=1 latches `key` into an internal register.
  - Clears `i` and `j` to 0.
  - Goes to INIT.
  - Later changes on `key` are ignored until the next run.
- **INIT:** writes s[i]=i, one write per cycle, for i=0..255, then goes to RD_I with i=0.
- **Swap loop**, repeated for i=0..255:
  - RD_I: drives `s_addr`=i.
  - CALC_J:
    - Latches si=`s_q`.
    - Updates j ← (j + `s_q` + key[i mod KEY_BYTES]) mod 256.
    - Drives `s_addr`=new j combinationally.
  - WR_I: latches sj=`s_q` and writes s[i]=`s_q`.
  - WR_J: writes s[j]=si. If i=255, goes to DONE; else i+1 and back to RD_I.
- **Key byte order:** key byte k = `key`[(KEY_BYTES-k)*8-1 -: 8], so byte 0 is the MSB byte.
- **Arithmetic:** all index arithmetic is modulo 256. The 8-bit adders wrap silently.
- **Boundary i==j:** both writes are issued as normal. The result is s[i] unchanged, with no special case.
- **DONE:** `finish`=1. Returns to IDLE when `start`=0. If `start` stays high, the block remains in DONE; it does not rerun.
- **`start` deasserted mid-run:** ignored; the run completes.
- **Reset mid-run:**
  - Immediate return to IDLE.
  - `s_wren` and `finish` drop asynchronously.
  - Scratch contents are left partial, and no recovery is attempted.
- **RAM read-during-write behaviour:** not relied upon. Each read is issued in a cycle without a write to the same address.

## Timing
- Reset values: `s_addr`=0, `s_data`=0, `s_wren`=0, `finish`=0. Internal `i`, `j`, si, sj and the key register are 0.
- Scratch read latency is 1 cycle. `s_q` is sampled in the cycle after `s_addr` is driven.
- INIT: 256 cycles with `s_wren`=1 throughout and `s_data`=`s_addr`.
- Each swap iteration takes 4 cycles. `s_wren`=1 only in WR_I and WR_J. The loop totals 1024 cycles.
- With `start` sampled at edge 0, `finish` rises after edge 1281 (1 + 256 + 1024).
- Total writes per run: 768.
- `s_addr`, `s_data` and `s_wren` are don't-care-free: in IDLE and DONE, `s_wren`=0.

## Configuration
- `KSA_INIT_PHASE_EN` defined:
  - INIT state is compiled in as described.
  - Latency is 1281 cycles.
- Not defined:
  - INIT is removed; IDLE goes directly to RD_I.
  - The scratch RAM must already hold the identity permutation (preloaded .mem or a separate initializer).
  - Latency is 1025 cycles and the run makes 512 writes.

## Test plan
- Key `0x000000`, `KSA_INIT_PHASE_EN` on, `start` held high:
  - The first 256 writes are addr=data=0..255.
  - The i=0 iteration writes data 0 to addr 0 twice (i==j self-swap).
  - The i=1 iteration writes s[1]=1 twice (j=1).
  - `finish` rises 1281 cycles after `start`.
- Key `0x00033C`:
  - The final scratch matches the software RC4 KSA model byte-for-byte and is a permutation of 0..255.
  - The downstream `decrypter` bench then produces the known plaintext.
- Reset pulled low at cycle 100 of INIT: `s_wren`=0 and `finish`=0 without waiting for a clock edge.
- After the same cycle-100 reset is released with `start`=1: a full run completes with identical final contents.
- `start` dropped at cycle 500: the run still completes and `finish` rises at 1281. Then, with `start`=0, the block returns to IDLE in 1 cycle and `finish`=0.
- `key` changed mid-run from `0x00033C` to `0xFFFFFF`: the final scratch equals the `0x00033C` result.
- Build without `KSA_INIT_PHASE_EN`, scratch preloaded with identity, key `0x00033C`:
  - Same final scratch as the `KSA_INIT_PHASE_EN` build.
  - `finish` at 1025 cycles.
  - 512 write cycles.

Source files
------------

// File: rtl/ksa_scheduler.sv
// ksa_scheduler: RC4 key-scheduling engine that fills the scratch RAM with the key-permuted S array.
// Define KSA_INIT_PHASE_EN to compile in the identity-fill phase; otherwise the RAM must be preloaded.
module ksa_scheduler #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int KEY_BYTES  = 3
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [KEY_BYTES*DATA_WIDTH-1:0] key,
  output logic [ADDR_WIDTH-1:0]           s_addr,
  output logic [DATA_WIDTH-1:0]           s_data,
  output logic                            s_wren,
  input  logic [DATA_WIDTH-1:0]           s_q,
  output logic                            finish
);

  localparam int KEY_W  = KEY_BYTES * DATA_WIDTH;
  localparam int KIDX_W = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  localparam logic [KIDX_W-1:0]     KIDX_LAST = KIDX_W'(KEY_BYTES - 1);
  localparam logic [ADDR_WIDTH-1:0] I_LAST    = '1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
`ifdef KSA_INIT_PHASE_EN
    INIT   = 3'd1,
`endif
    RD_I   = 3'd2,
    CALC_J = 3'd3,
    WR_I   = 3'd4,
    WR_J   = 3'd5,
    DONE   = 3'd6
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   i_q, i_d;
  logic [ADDR_WIDTH-1:0]   j_q, j_d;
  logic [DATA_WIDTH-1:0]   si_q, si_d;
  logic [KEY_W-1:0]        key_q, key_d;
  logic [KIDX_W-1:0]       kidx_q, kidx_d;
  logic                    s_wren_q, s_wren_d;
  logic                    finish_q, finish_d;

  logic [DATA_WIDTH-1:0]   key_byte [KEY_BYTES];
  logic [DATA_WIDTH-1:0]   cur_key;
  logic [ADDR_WIDTH-1:0]   j_calc;

  // Key byte 0 is the most significant byte of the key word.
  for (genvar gi = 0; gi < KEY_BYTES; gi++) begin : g_key_byte
    assign key_byte[gi] = key_q[(KEY_BYTES-gi)*DATA_WIDTH-1 -: DATA_WIDTH];
  end

  // kidx tracks i mod KEY_BYTES incrementally, avoiding a divider.
  assign cur_key = key_byte[kidx_q];
  assign j_calc  = j_q + ADDR_WIDTH'(s_q) + ADDR_WIDTH'(cur_key);

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    si_d    = si_q;
    key_d   = key_q;
    kidx_d  = kidx_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          key_d  = key;
          i_d    = '0;
          j_d    = '0;
          kidx_d = '0;
`ifdef KSA_INIT_PHASE_EN
          state_d = INIT;
`else
          state_d = RD_I;
`endif
        end
      end
`ifdef KSA_INIT_PHASE_EN
      INIT: begin
        i_d = i_q + 1'b1;
        if (i_q == I_LAST) begin
          state_d = RD_I;
        end
      end
`endif
      RD_I: begin
        state_d = CALC_J;
      end
      CALC_J: begin
        si_d    = s_q;
        j_d     = j_calc;
        state_d = WR_I;
      end
      WR_I: begin
        state_d = WR_J;
      end
      WR_J: begin
        if (i_q == I_LAST) begin
          state_d = DONE;
        end else begin
          i_d     = i_q + 1'b1;
          kidx_d  = (kidx_q == KIDX_LAST) ? '0 : kidx_q + 1'b1;
          state_d = RD_I;
        end
      end
      DONE: begin
        if (!start) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Write enable and finish are registered, decoded from the state being entered.
    s_wren_d = (state_d == WR_I) || (state_d == WR_J);
`ifdef KSA_INIT_PHASE_EN
    if (state_d == INIT) begin
      s_wren_d = 1'b1;
    end
`endif
    finish_d = (state_d == DONE);
  end

  // Address and data depend on s_q in CALC_J/WR_I, so they are decoded from the current state.
  always_comb begin
    s_addr = '0;
    s_data = '0;
    case (state_q)
`ifdef KSA_INIT_PHASE_EN
      INIT: begin
        s_addr = i_q;
        s_data = DATA_WIDTH'(i_q);
      end
`endif
      RD_I: begin
        s_addr = i_q;
      end
      CALC_J: begin
        s_addr = j_calc;
      end
      WR_I: begin
        s_addr = i_q;
        s_data = s_q;
      end
      WR_J: begin
        s_addr = j_q;
        s_data = si_q;
      end
      default: begin
        s_addr = '0;
        s_data = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      i_q      <= '0;
      j_q      <= '0;
      si_q     <= '0;
      key_q    <= '0;
      kidx_q   <= '0;
      s_wren_q <= 1'b0;
      finish_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      i_q      <= i_d;
      j_q      <= j_d;
      si_q     <= si_d;
      key_q    <= key_d;
      kidx_q   <= kidx_d;
      s_wren_q <= s_wren_d;
      finish_q <= finish_d;
    end
  end

  assign s_wren = s_wren_q;
  assign finish = finish_q;

endmodule

// File: tb/tb_ksa_scheduler.sv
// Bench for ksa_scheduler: random and directed keys checked against a software RC4 KSA model.
module tb_ksa_scheduler;

`ifdef KSA_INIT_PHASE_EN
  localparam int LAT    = 1281;
  localparam int NWRITE = 768;
  localparam int BASE   = 256;
`else
  localparam int LAT    = 1025;
  localparam int NWRITE = 512;
  localparam int BASE   = 0;
`endif
  localparam int BUDGET = 2000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [23:0] key;
  logic [7:0]  s_addr;
  logic [7:0]  s_data;
  logic        s_wren;
  logic [7:0]  s_q;
  logic        finish;

  logic [7:0]  mem [256];
  logic        preload_req;

  logic [7:0]  exp_s [256];
  int          exp_a[$];
  int          exp_d[$];
  int          wlog_a[$];
  int          wlog_d[$];

  int          n_chk  = 0;
  int          n_pass = 0;

  ksa_scheduler #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .KEY_BYTES(3)) dut (
    .clk    (clk),
    .rst    (rst_n),
    .start  (start),
    .key    (key),
    .s_addr (s_addr),
    .s_data (s_data),
    .s_wren (s_wren),
    .s_q    (s_q),
    .finish (finish)
  );

  always #5 clk = ~clk;

  // Scratch RAM with one-cycle registered read; preload fills identity (or junk when INIT runs).
  always @(posedge clk) begin
    if (preload_req) begin
      for (int n = 0; n < 256; n++) begin
`ifdef KSA_INIT_PHASE_EN
        mem[n] <= 8'(n) ^ 8'hA5;
`else
        mem[n] <= 8'(n);
`endif
      end
    end else if (s_wren) begin
      mem[s_addr] <= s_data;
    end
    s_q <= mem[s_addr];
  end

  always @(negedge clk) begin
    if (rst_n && s_wren) begin
      wlog_a.push_back(int'(s_addr));
      wlog_d.push_back(int'(s_data));
    end
  end

  task automatic check(input string tag, input longint obs, input longint expv);
    n_chk++;
    if (obs == expv) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
  endtask

  function automatic void build_model(input logic [23:0] k);
    int j;
    logic [7:0] t;
    logic [7:0] kb;
    exp_a.delete();
    exp_d.delete();
    for (int n = 0; n < 256; n++) begin
      exp_s[n] = 8'(n);
`ifdef KSA_INIT_PHASE_EN
      exp_a.push_back(n);
      exp_d.push_back(n);
`endif
    end
    j = 0;
    for (int n = 0; n < 256; n++) begin
      kb = 8'(k >> (8 * (2 - (n % 3))));
      j = (j + int'(exp_s[n]) + int'(kb)) % 256;
      exp_a.push_back(n);
      exp_d.push_back(int'(exp_s[j]));
      exp_a.push_back(j);
      exp_d.push_back(int'(exp_s[n]));
      t = exp_s[n];
      exp_s[n] = exp_s[j];
      exp_s[j] = t;
    end
  endfunction

  task automatic preload();
    preload_req = 1'b1;
    @(posedge clk);
    #1;
    preload_req = 1'b0;
  endtask

  task automatic run_ksa(input logic [23:0] k, input int drop_at, input int chg_at, output int lat);
    int n;
    lat = -1;
    wlog_a.delete();
    wlog_d.delete();
    key = k;
    start = 1'b1;
    n = 0;
    while (n < BUDGET) begin
      @(posedge clk);
      n++;
      #1;
      if (n == drop_at) start = 1'b0;
      if (n == chg_at) key = 24'hFFFFFF;
      if (finish) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic verify_run(input string tag, input int lat);
    int bad;
    int seen [256];
    int perm_ok;
    check({tag, "_lat"}, lat, LAT);
    check({tag, "_nwr"}, wlog_a.size(), NWRITE);
    bad = 0;
    for (int n = 0; n < exp_a.size(); n++) begin
      if (n >= wlog_a.size()) bad++;
      else if (wlog_a[n] != exp_a[n] || wlog_d[n] != exp_d[n]) bad++;
    end
    check({tag, "_wlog_bad"}, bad, 0);
    bad = 0;
    for (int n = 0; n < 256; n++) begin
      seen[n] = 0;
      if (mem[n] != exp_s[n]) bad++;
    end
    check({tag, "_ram_bad"}, bad, 0);
    perm_ok = 1;
    for (int n = 0; n < 256; n++) seen[int'(mem[n])]++;
    for (int n = 0; n < 256; n++) if (seen[n] != 1) perm_ok = 0;
    check({tag, "_perm"}, perm_ok, 1);
    $display("run %s: latency %0d, writes %0d", tag, lat, wlog_a.size());
  endtask

  function automatic int qget(input int which, input int idx);
    if (which == 0) return (idx < wlog_a.size()) ? wlog_a[idx] : -1;
    return (idx < wlog_d.size()) ? wlog_d[idx] : -1;
  endfunction

  initial begin
    int lat;
    int bad;
    logic [23:0] rk;
    rst_n = 1'b0;
    start = 1'b0;
    key = '0;
    preload_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_addr", s_addr, 0);
    check("rst_data", s_data, 0);
    check("rst_wren", s_wren, 0);
    check("rst_finish", finish, 0);
    preload();
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // All-zero key, start held high through DONE.
    build_model(24'h000000);
    run_ksa(24'h000000, 0, 0, lat);
    verify_run("k0", lat);
    bad = 0;
    for (int n = 0; n < BASE; n++) if (qget(0, n) != n || qget(1, n) != n) bad++;
    check("k0_init_ident_bad", bad, 0);
    check("k0_i0_wr_i_addr", qget(0, BASE), 0);
    check("k0_i0_wr_j_data", qget(1, BASE + 1), 0);
    check("k0_i1_wr_i_data", qget(1, BASE + 2), 1);
    check("k0_i1_wr_j_addr", qget(0, BASE + 3), 1);
    repeat (3) @(posedge clk);
    #1;
    check("k0_hold_finish", finish, 1);
    check("k0_hold_wren", s_wren, 0);
    start = 1'b0;
    @(posedge clk);
    #1;
    check("k0_idle_finish", finish, 0);

    // Reference key.
    preload();
    build_model(24'h00033C);
    run_ksa(24'h00033C, 0, 0, lat);
    verify_run("k33c", lat);
    start = 1'b0;
    @(posedge clk);
    #1;

    // Asynchronous reset 100 cycles into a run.
    preload();
    key = 24'h00033C;
    start = 1'b1;
    repeat (100) @(posedge clk);
    #1;
`ifdef KSA_INIT_PHASE_EN
    check("mid_wren_before", s_wren, 1);
`endif
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_wren", s_wren, 0);
    check("async_rst_finish", finish, 0);
    start = 1'b0;
    preload();
    rst_n = 1'b1;
    run_ksa(24'h00033C, 0, 0, lat);
    verify_run("rerun", lat);
    start = 1'b0;
    @(posedge clk);
    #1;

    // Key changes after it has been latched.
    preload();
    run_ksa(24'h00033C, 0, 300, lat);
    verify_run("keychg", lat);
    start = 1'b0;
    @(posedge clk);
    #1;

    // Start dropped mid-run: run completes, then back to IDLE on the next edge.
    preload();
    run_ksa(24'h00033C, 500, 0, lat);
    verify_run("drop", lat);
    @(posedge clk);
    #1;
    check("drop_idle_finish", finish, 0);
    check("drop_idle_wren", s_wren, 0);

    // Random keys.
    for (int r = 0; r < 3; r++) begin
      rk = 24'($urandom);
      preload();
      build_model(rk);
      run_ksa(rk, 0, 0, lat);
      verify_run($sformatf("rnd%0d_%06h", r, rk), lat);
      start = 1'b0;
      @(posedge clk);
      #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
